// File: rtl/nrisc_idata_loader.sv
// nrisc_idata_loader: assembles a framed host byte stream into 16-bit words and writes them to I-Data.
module nrisc_idata_loader #(
  parameter int          PROG_AW     = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [15:0]        IDATA_PROG_data,
  output logic [PROG_AW-1:0] IDATA_PROG_addr,
  output logic               IDATA_PROG_write,
  output logic               core_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [1:0]         err_code
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_LEN = 17'(1) << PROG_AW;
  typedef enum logic [2:0] {S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CHK, S_DONE, S_ERR} state_t;
  state_t state, nxt;
  logic [7:0] len_h, hbyte, sum;
  logic [15:0] len, len_in;
  logic [PROG_AW:0] cnt;
  logic [TW-1:0] idle;
  logic acc, active, tmo, over, last;
  logic [1:0] ecode;
  assign rx_ready = ~IDATA_PROG_write;
  assign acc = rx_valid & rx_ready;
  assign active = state inside {S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CHK};
  assign tmo = active & ~acc & (idle == TW'(TIMEOUT_CYC - 1));
  assign len_in = {len_h, rx_data};
  assign over = {1'b0, len_in} > MAX_LEN;
  assign last = 16'(cnt) + 16'd1 == len;
  assign ecode = tmo ? 2'b01 : state == S_LEN_L ? 2'b10 : 2'b11;
  always_comb begin
    nxt = state;
    if (tmo) nxt = S_ERR;
    else if (acc)
      case (state)
        S_IDLE, S_DONE, S_ERR: nxt = rx_data == SYNC_BYTE ? S_LEN_H : state;
        S_LEN_H:  nxt = S_LEN_L;
        S_LEN_L:  nxt = over ? S_ERR : len_in == 16'd0 ? S_CHK : S_DATA_H;
        S_DATA_H: nxt = S_DATA_L;
        S_DATA_L: nxt = last ? S_CHK : S_DATA_H;
        S_CHK:    nxt = rx_data == sum ? S_DONE : S_ERR;
        default:  nxt = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      len_h <= '0;
      hbyte <= '0;
      sum <= '0;
      len <= '0;
      cnt <= '0;
      idle <= '0;
      IDATA_PROG_data <= '0;
      IDATA_PROG_addr <= '0;
      IDATA_PROG_write <= 1'b0;
      core_hold <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
      err_code <= '0;
    end else begin
      state <= nxt;
      IDATA_PROG_write <= 1'b0;
      idle <= (!active || acc) ? '0 : idle + TW'(1);
      if (acc)
        case (state)
          S_IDLE, S_DONE, S_ERR:
            if (rx_data == SYNC_BYTE) begin
              load_done <= 1'b0;
              load_err <= 1'b0;
              err_code <= '0;
              cnt <= '0;
              sum <= '0;
              len <= '0;
              core_hold <= 1'b1;
            end
          S_LEN_H: len_h <= rx_data;
          S_LEN_L: len <= len_in;
          S_DATA_H: begin
            hbyte <= rx_data;
            sum <= sum + rx_data;
          end
          S_DATA_L: begin
            IDATA_PROG_data <= {hbyte, rx_data};
            IDATA_PROG_addr <= cnt[PROG_AW-1:0];
            IDATA_PROG_write <= 1'b1;
            cnt <= cnt + (PROG_AW + 1)'(1);
            sum <= sum + rx_data;
          end
          default: ;
        endcase
      if (nxt == S_ERR && state != S_ERR) begin
        load_err <= 1'b1;
        err_code <= ecode;
      end
      if (nxt == S_DONE && state != S_DONE) begin
        load_done <= 1'b1;
        core_hold <= 1'b0;
      end
    end
  end
endmodule
